// File: rtl/display_scan.sv
// Purpose: time-multiplexed digit scanner feeding decode_7seg (one nibble, one anode per slot).
// Latency: outputs are registered and lag the (idx, cnt) scan state by one clock.
// Backpressure: none; free-running scan, and load is a fire-and-forget strobe captured at any cycle.
module display_scan #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic [3:0]            data,
    output logic                  select,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame_done
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   pending;
    logic                  pending_valid;
    logic [4*DIGITS-1:0]   shadow;
    logic                  frame_seen;

    logic                  slot_end;
    logic                  frame_end;
    logic [3:0]            cur_nib;
    logic                  upper_nz;
    logic                  blanked;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // Prescale counter and digit index: cnt counts within a slot, idx steps on each slot wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Pending/shadow pair: shadow only moves at the frame boundary so a frame is never torn.
    // A load landing on the boundary cycle bypasses pending and goes straight into shadow.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending       <= '0;
            pending_valid <= 1'b0;
            shadow        <= '0;
        end else if (frame_end) begin
            if (load) begin
                shadow <= value;
            end else if (pending_valid) begin
                shadow <= pending;
            end
            pending_valid <= 1'b0;
        end else if (load) begin
            pending       <= value;
            pending_valid <= 1'b1;
        end
    end

    // Marks that at least one full frame has completed since reset, gating frame_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_seen <= 1'b0;
        end else if (frame_end) begin
            frame_seen <= 1'b1;
        end
    end

    // Current nibble and whether this digit and everything more significant is zero.
    always_comb begin
        cur_nib  = 4'd0;
        upper_nz = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == idx) begin
                cur_nib = shadow[4*i +: 4];
            end
            if ((IW'(i) >= idx) && (shadow[4*i +: 4] != 4'd0)) begin
                upper_nz = 1'b1;
            end
        end
        blanked = blank_lz && (idx != '0) && !upper_nz;
    end

    // Registered outputs: first cycle of each slot is dead time with all anodes off.
    always_ff @(posedge clk) begin
        if (rst) begin
            data       <= 4'd0;
            select     <= 1'b0;
            digit_en   <= '0;
            frame_done <= 1'b0;
        end else begin
            data       <= blanked ? 4'd0 : cur_nib;
            select     <= !blanked;
            digit_en   <= (cnt == '0) ? '0 : (DIGITS'(1) << idx);
            frame_done <= frame_seen && (cnt == '0) && (idx == '0);
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// Purpose: randomized plus directed stimulus for two display_scan configurations against a slot-time model.
// Latency: expectations are formed one clock after the stimulus edge, matching the registered outputs.
// Backpressure: not applicable; all checks are on fixed per-cycle timing.
module tb_display_scan;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        load;
    logic        blank_lz;
    logic [15:0] value;

    logic [3:0]  data_a;
    logic        select_a;
    logic [3:0]  en_a;
    logic        fd_a;

    logic [3:0]  data_b;
    logic        select_b;
    logic [2:0]  en_b;
    logic        fd_b;

    display_scan #(.DIGITS(4), .PRESCALE(4)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .load       (load),
        .blank_lz   (blank_lz),
        .data       (data_a),
        .select     (select_a),
        .digit_en   (en_a),
        .frame_done (fd_a)
    );

    display_scan #(.DIGITS(3), .PRESCALE(2)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .value      (value[11:0]),
        .load       (load),
        .blank_lz   (blank_lz),
        .data       (data_b),
        .select     (select_b),
        .digit_en   (en_b),
        .frame_done (fd_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state, one entry per configuration: edges since reset release,
    // displayed value, and the pending value waiting for the next frame.
    int          cfg_d [2] = '{4, 3};
    int          cfg_p [2] = '{4, 2};
    int          m_n   [2];
    logic [15:0] m_shadow [2];
    logic [15:0] m_pend   [2];
    bit          m_pv     [2];
    int          fd_count [2];

    logic [3:0]  e_data [2];
    logic        e_sel  [2];
    logic [3:0]  e_en   [2];
    logic        e_fd   [2];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Expected outputs for the edge just taken, from slot position in time since reset release.
    task automatic model_step(input int c);
        int          d;
        int          p;
        int          f;
        int          pos;
        int          slot;
        int          ins;
        logic [15:0] mask;
        logic [15:0] v;
        logic [15:0] upper;
        bit          blanked;
        d    = cfg_d[c];
        p    = cfg_p[c];
        f    = d * p;
        mask = (c == 0) ? 16'hFFFF : 16'h0FFF;
        v    = value & mask;
        if (rst) begin
            m_n[c]      = 0;
            m_shadow[c] = 16'h0;
            m_pend[c]   = 16'h0;
            m_pv[c]     = 1'b0;
            e_data[c]   = 4'd0;
            e_sel[c]    = 1'b0;
            e_en[c]     = 4'd0;
            e_fd[c]     = 1'b0;
        end else begin
            m_n[c]    = m_n[c] + 1;
            pos       = (m_n[c] - 1) % f;
            slot      = pos / p;
            ins       = pos % p;
            upper     = m_shadow[c] >> (4 * slot);
            blanked   = blank_lz && (slot > 0) && (upper == 16'h0);
            e_en[c]   = (ins == 0) ? 4'd0 : 4'(1 << slot);
            e_fd[c]   = (pos == 0) && (m_n[c] > 1);
            e_sel[c]  = !blanked;
            e_data[c] = blanked ? 4'd0 : upper[3:0];
            if (pos == f - 1) begin
                if (load) m_shadow[c] = v;
                else if (m_pv[c]) m_shadow[c] = m_pend[c];
                m_pv[c] = 1'b0;
            end else if (load) begin
                m_pend[c] = v;
                m_pv[c]   = 1'b1;
            end
        end
        if (e_fd[c]) fd_count[c]++;
    endtask

    // Apply one cycle of stimulus, let the DUTs take the edge, then compare both against the model.
    task automatic tick(input logic r, input logic l, input logic [15:0] v, input logic b);
        rst      = r;
        load     = l;
        value    = v;
        blank_lz = b;
        @(posedge clk);
        #1;
        model_step(0);
        model_step(1);
        check("a_digit_en",   32'(en_a),     32'(e_en[0]));
        check("a_data",       32'(data_a),   32'(e_data[0]));
        check("a_select",     32'(select_a), 32'(e_sel[0]));
        check("a_frame_done", 32'(fd_a),     32'(e_fd[0]));
        check("b_digit_en",   32'(en_b),     32'(e_en[1][2:0]));
        check("b_data",       32'(data_b),   32'(e_data[1]));
        check("b_select",     32'(select_b), 32'(e_sel[1]));
        check("b_frame_done", 32'(fd_b),     32'(e_fd[1]));
        check("b_onehot0",    32'($onehot0(en_b)), 32'd1);
    endtask

    task automatic idle(input int n, input logic b);
        for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 16'h0, b);
    endtask

    // Idle until configuration A's next edge falls at the given position within its 16-cycle frame.
    task automatic align_a(input int pos);
        for (int k = 0; k < 16; k++) begin
            if ((m_n[0] % 16) == pos) break;
            tick(1'b0, 1'b0, 16'h0, 1'b0);
        end
    endtask

    initial begin
        int          fd_before;
        logic        r_rst;
        logic        r_load;
        logic        r_blank;
        logic [15:0] r_val;
        rst      = 1'b1;
        load     = 1'b0;
        blank_lz = 1'b0;
        value    = 16'h0;
        for (int i = 0; i < 2; i++) begin
            m_n[i] = 0; m_shadow[i] = 16'h0; m_pend[i] = 16'h0; m_pv[i] = 1'b0;
            fd_count[i] = 0;
        end

        // Reset for three cycles, then release and walk the first slots.
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 16'h0, 1'b0);
        idle(5, 1'b0);

        // Mid-frame load at edge 6; it appears only in the following frame.
        tick(1'b0, 1'b1, 16'h1234, 1'b0);
        idle(34, 1'b0);

        // Leading-zero blanking on 0x0050, then on all zeros.
        tick(1'b0, 1'b1, 16'h0050, 1'b1);
        idle(36, 1'b1);
        tick(1'b0, 1'b1, 16'h0000, 1'b1);
        idle(36, 1'b1);

        // Pending 0x1111 is overridden by a load landing exactly on the boundary cycle.
        align_a(4);
        tick(1'b0, 1'b1, 16'h1111, 1'b0);
        align_a(15);
        tick(1'b0, 1'b1, 16'hABCD, 1'b0);
        idle(20, 1'b0);
        check("boundary_load_shadow", 32'(m_shadow[0]), 32'h0000ABCD);

        // Reset during slot 2 of a 0x1234 frame discards a pending load.
        tick(1'b0, 1'b1, 16'h1234, 1'b0);
        idle(20, 1'b0);
        align_a(9);
        tick(1'b0, 1'b1, 16'h5555, 1'b0);
        tick(1'b1, 1'b0, 16'h0, 1'b0);
        idle(40, 1'b0);

        // Five frames of configuration B: frame_done every 6 cycles.
        fd_before = fd_count[1];
        idle(31, 1'b0);
        check("b_five_frames", 32'(fd_count[1] - fd_before), 32'd5);

        // Randomized traffic with occasional resets, loads and blanking changes.
        r_blank = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            r_rst  = ($urandom_range(199) == 0);
            r_load = ($urandom_range(9) == 0);
            r_val  = 16'($urandom);
            if ($urandom_range(3) == 0) r_val = r_val & 16'h00FF;
            if ($urandom_range(29) == 0) r_blank = ~r_blank;
            tick(r_rst, r_load, r_val, r_blank);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scan.md
Name: display_scan

Overview:
- Time-multiplexed scanner feeding the 7-segment decoder; sits directly upstream of decode_7seg.
- Holds a DIGITS-wide BCD/hex value and cycles through the digits, one slot per digit.
- Each slot presents one nibble on data/select to the decoder and drives a one-hot digit enable to the display.
- Provides tear-free value updates, leading-zero blanking and a dead-time cycle between digits to suppress ghosting.

Parameters:
- DIGITS, 4, number of multiplexed digits (>=2).
- PRESCALE, 1000, clock cycles per digit slot (>=2).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset.
- value  input  4*DIGITS  new display value; nibble i is digit i, digit 0 least significant/rightmost.
- load  input  1  single-cycle strobe; captures value into the pending register.
- blank_lz  input  1  when 1, suppress leading zeros.
- data  output  4  nibble to decoder.
- select  output  1  decoder enable; 0 blanks the segments.
- digit_en  output  DIGITS  one-hot digit (anode) enable.
- frame_done  output  1  one-cycle pulse at each frame boundary.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- State: prescale counter cnt (0..PRESCALE-1), digit index idx (0..DIGITS-1), pending register, shadow register.
- Reset values: cnt=0, idx=0, pending=0, shadow=0, data=0, select=0, digit_en=0, frame_done=0.
- Scan sequence:
  - cnt increments every cycle.
  - At cnt==PRESCALE-1, cnt wraps to 0 and idx advances; idx wraps from DIGITS-1 to 0.
  - Frame = DIGITS*PRESCALE cycles.
- Outputs are registered, one cycle behind (idx, cnt):
  - digit_en = 0 for the cycle reflecting cnt==0 (dead time).
  - Otherwise digit_en = 1<<idx.
  - data = shadow nibble[idx] for the whole slot, including the dead-time cycle.
- First slot after reset release: first clock edge with rst=0 sets cnt=1. Outputs after that edge show digit_en=0 (dead time), data=shadow[0]=0.
- select:
  - 1 in every slot unless blanked.
  - With blank_lz=1, digit i>0 is blanked (select=0, data=0) when nibble i and all more significant nibbles of shadow are 0.
  - Digit 0 is never blanked.
  - With blank_lz=0, select=1 always (outside reset).
  - blank_lz is sampled every cycle, so a change takes effect on the next output update.
- Load / tear-free update:
  - load=1 copies value into pending and sets pending_valid.
  - At the frame boundary (idx DIGITS-1 -> 0, i.e. cnt wrap with idx==DIGITS-1): if pending_valid, shadow <= pending and pending_valid is cleared.
  - Shadow never changes mid-frame.
- Simultaneous events:
  - load on the boundary cycle: the value on that cycle's bus is written directly to shadow, and pending_valid ends clear.
  - Multiple loads within a frame: the last one wins.
- frame_done: registered pulse, high for exactly one cycle, coincident with the first output cycle of slot 0 of each new frame (the cycle where digit 0's dead time is shown). It is not asserted for the first slot after reset.
- Reset mid-operation: rst=1 on any cycle forces all reset values on the next edge and discards pending. Scanning restarts at slot 0 when rst falls.
- Outputs never present two bits set in digit_en, and never change data within a slot.

Test Plan (DIGITS=4, PRESCALE=4 unless stated):
1. rst high 3 cycles, then low:
   - During reset: all outputs 0.
   - After release, edge 1: digit_en=0000, select=1, data=0.
   - Edges 2-4: digit_en=0001, data=0.
   - Edge 5: digit_en=0000; edges 6-8: digit_en=0010.
2. load=1 with value=16'h1234 at edge 6 (mid-frame):
   - Frame 1 digits stay 0.
   - frame_done pulses once at edge 17.
   - Next frame: data=4,3,2,1 in slots 0-3, digit_en 0001, 0010, 0100, 1000.
3. blank_lz=1, shadow=16'h0050:
   - Slots 3 and 2: select=0.
   - Slot 1: data=5, select=1. Slot 0: data=0, select=1.
   - Then shadow=16'h0000: only slot 0 has select=1.
4. load value=16'hABCD on the exact boundary cycle, with a prior pending 16'h1111 loaded mid-frame: the next frame shows D,C,B,A; 1111 is never displayed.
5. rst asserted for 1 cycle during slot 2 of a frame showing 16'h1234:
   - Next edge: all outputs 0 and shadow=0.
   - Scanning restarts at slot 0 with data=0.
   - A pending load issued before the reset is discarded.
6. Run 5 frames with PRESCALE=2, DIGITS=3: frame_done pulses every 6 cycles. digit_en is one-hot or zero on every cycle, with zero on the first cycle of each slot.
